// File: rtl/seq_adder_pkg.sv
// Shared encodings for the sequential channel adder: operation modes and FSM states.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_SUB   = 2'b01,
    MODE_ACC   = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUM  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_adder_step.sv
// One WIDTH-bit add or subtract step; cout is carry-out for add, borrow for subtract.
// Purely combinational, no latency, no flow control.
module seq_adder_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] ext;

  // The extra top bit of the widened difference is set exactly when a < b.
  always_comb begin
    if (sub) ext = {1'b0, a} - {1'b0, b};
    else     ext = {1'b0, a} + {1'b0, b};
  end

  assign sum  = ext[WIDTH-1:0];
  assign cout = ext[WIDTH];

endmodule

// File: rtl/seq_adder_core.sv
// Sequential CHANNELS-operand ADD/SUB/ACC reducer, one channel per cycle; result/done CHANNELS cycles after start.
// No backpressure: a start seen while busy or done is dropped and latched in the sticky overrun flag.
module seq_adder_core #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      ti_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*WIDTH-1:0] operands,
  output logic [WIDTH-1:0]          result,
  output logic                      carry,
  output logic                      overrun,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               count
);

  import seq_adder_pkg::*;

  localparam int              IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  state_e                    state, state_nxt;
  mode_e                     op_mode;
  logic [CHANNELS*WIDTH-1:0] snap;
  logic [WIDTH-1:0]          acc;
  logic                      acc_carry;
  logic [IDX_W-1:0]          idx;

  logic                      accept, clear_req, ignored;
  logic [WIDTH-1:0]          ch0;
  logic [WIDTH-1:0]          step_a, step_b, step_sum;
  logic                      step_sub, step_cout;

  assign ch0 = operands[WIDTH-1:0];

  // The step unit is shared: in IDLE it forms result+ch0 for ACC, in SUM it folds in the next channel.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clear_req = 1'b0;
    ignored   = 1'b0;
    step_a    = acc;
    step_b    = snap[int'(idx)*WIDTH +: WIDTH];
    step_sub  = (op_mode == MODE_SUB);

    case (state)
      IDLE: begin
        step_a   = result;
        step_b   = ch0;
        step_sub = 1'b0;
        if (start) begin
          if (done) begin
            ignored = 1'b1;
          end else if (mode_e'(mode) == MODE_CLEAR) begin
            clear_req = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = (CHANNELS > 1) ? SUM : DONE;
          end
        end
      end
      SUM: begin
        ignored = start;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        ignored   = start;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  seq_adder_step #(.WIDTH(WIDTH)) u_step (
    .a    (step_a),
    .b    (step_b),
    .sub  (step_sub),
    .sum  (step_sum),
    .cout (step_cout)
  );

  always_ff @(posedge ti_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      result    <= '0;
      carry     <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      acc       <= '0;
      acc_carry <= 1'b0;
      idx       <= '0;
      op_mode   <= MODE_ADD;
      snap      <= '0;
    end else begin
      // busy trails the SUM state by one edge, so it drops in the done cycle.
      busy <= (state == SUM);
      done <= clear_req || (state == DONE);
      if (ignored) overrun <= 1'b1;

      if (accept) begin
        snap    <= operands;
        op_mode <= mode_e'(mode);
        idx     <= IDX_W'(1);
        if (mode_e'(mode) == MODE_ACC) begin
          acc       <= step_sum;
          acc_carry <= step_cout;
        end else begin
          acc       <= ch0;
          acc_carry <= 1'b0;
        end
      end

      if (clear_req) begin
        result  <= '0;
        carry   <= 1'b0;
        overrun <= 1'b0;
      end

      if (state == SUM) begin
        acc       <= step_sum;
        acc_carry <= acc_carry | step_cout;
        idx       <= idx + IDX_W'(1);
      end

      if (state == DONE) begin
        result <= acc;
        carry  <= acc_carry;
        count  <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_adder_core.sv
// Scoreboard bench for seq_adder_core: a 4-channel and a 1-channel instance driven with directed vectors.
module tb_seq_adder_core;

  typedef struct {
    logic [15:0] res;
    logic        cy;
    logic [15:0] cnt;
    logic        ov;
    int          done_cyc;
    int          busy_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start1;
  logic [1:0]  mode4, mode1;
  logic [63:0] ops4;
  logic [15:0] ops1;
  logic [15:0] res4, res1, cnt4, cnt1;
  logic        cy4, cy1, ov4, ov1, busy4, busy1, done4, done1;

  always #5 clk = ~clk;

  seq_adder_core #(.WIDTH(16), .CHANNELS(4)) dut4 (
    .ti_clk(clk), .reset(rst), .start(start4), .mode(mode4), .operands(ops4),
    .result(res4), .carry(cy4), .overrun(ov4), .busy(busy4), .done(done4), .count(cnt4)
  );

  seq_adder_core #(.WIDTH(16), .CHANNELS(1)) dut1 (
    .ti_clk(clk), .reset(rst), .start(start1), .mode(mode1), .operands(ops1),
    .result(res1), .carry(cy1), .overrun(ov1), .busy(busy1), .done(done1), .count(cnt1)
  );

  int   cyc = 0;
  exp_t q4[$], q1[$];
  exp_t e4, e1;
  int   n_cmp = 0, n_fail = 0;
  int   busy_run4 = 0, busy_run1 = 0, n_done4 = 0, n_done1 = 0;
  bit   busy1_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (busy4) busy_run4++;
    if (done4) begin
      n_done4++;
      if (q4.size() == 0) begin
        check("spurious_done4", 1, 0);
      end else begin
        e4 = q4.pop_front();
        check("result4",   res4,      e4.res);
        check("carry4",    cy4,       e4.cy);
        check("count4",    cnt4,      e4.cnt);
        check("overrun4",  ov4,       e4.ov);
        check("done_cyc4", cyc,       e4.done_cyc);
        check("busy_len4", busy_run4, e4.busy_n);
      end
      busy_run4 = 0;
    end
  end

  always @(negedge clk) begin
    if (busy1) begin
      busy_run1++;
      busy1_seen = 1'b1;
    end
    if (done1) begin
      n_done1++;
      if (q1.size() == 0) begin
        check("spurious_done1", 1, 0);
      end else begin
        e1 = q1.pop_front();
        check("result1",   res1,      e1.res);
        check("carry1",    cy1,       e1.cy);
        check("count1",    cnt1,      e1.cnt);
        check("done_cyc1", cyc,       e1.done_cyc);
        check("busy_len1", busy_run1, e1.busy_n);
      end
      busy_run1 = 0;
    end
  end

  task automatic drain();
    int n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() + q1.size() != 0) begin
      check("done_timeout", q4.size() + q1.size(), 0);
      q4.delete();
      q1.delete();
    end
  endtask

  // lat: cycles from the accepting edge to the edge that raises done.
  task automatic issue(input bit to1, input logic [1:0] md, input logic [63:0] ops, input bit dbl,
                       input logic [15:0] x_res, input logic x_cy, input logic [15:0] x_cnt,
                       input logic x_ov, input int lat, input int x_busy);
    exp_t e;
    @(negedge clk);
    e.res = x_res; e.cy = x_cy; e.cnt = x_cnt; e.ov = x_ov;
    e.done_cyc = cyc + 1 + lat;
    e.busy_n   = x_busy;
    if (to1) begin
      start1 = 1'b1; mode1 = md; ops1 = ops[15:0];
      q1.push_back(e);
    end else begin
      start4 = 1'b1; mode4 = md; ops4 = ops;
      q4.push_back(e);
    end
    @(negedge clk);
    if (dbl) begin
      ops4  = {4{16'h0005}};
      mode4 = 2'b00;
      @(negedge clk);
    end
    start4 = 1'b0;
    start1 = 1'b0;
    ops4   = {$urandom, $urandom};
    ops1   = 16'($urandom);
    mode4  = 2'($urandom);
    mode1  = 2'($urandom);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
    mode4 = 2'b00; mode1 = 2'b00; ops4 = '0; ops1 = '0;
    repeat (3) @(negedge clk);
    check("rst_result", res4, 0);
    check("rst_carry",  cy4,  0);
    check("rst_ovr",    ov4,  0);
    check("rst_busy",   busy4, 0);
    check("rst_done",   done4, 0);
    check("rst_count",  cnt4, 0);
    rst = 1'b0;

    //     to1 mode   ops {ch3,ch2,ch1,ch0}                                   dbl res       cy  cnt ov lat busy
    issue(0, 2'b00, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0, 16'h000A, 0, 1, 0, 4, 3);
    issue(0, 2'b00, {16'h0000, 16'h0000, 16'h0001, 16'hFFFF}, 0, 16'h0000, 1, 2, 0, 4, 3);
    issue(0, 2'b01, {16'h0003, 16'h0002, 16'h0001, 16'h0010}, 0, 16'h000A, 0, 3, 0, 4, 3);
    issue(0, 2'b01, {16'h0000, 16'h0000, 16'h0001, 16'h0000}, 0, 16'hFFFF, 1, 4, 0, 4, 3);
    issue(0, 2'b00, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1, 16'h000A, 0, 5, 1, 4, 3);
    issue(0, 2'b10, {16'h0001, 16'h0001, 16'h0001, 16'h0001}, 0, 16'h000E, 0, 6, 1, 4, 3);
    issue(0, 2'b11, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 0, 16'h0000, 0, 6, 0, 0, 0);
    issue(0, 2'b00, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 0, 16'hFFFF, 0, 7, 0, 4, 3);
    issue(0, 2'b10, {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 0, 16'h0000, 1, 8, 0, 4, 3);

    issue(1, 2'b00, 64'h1234, 0, 16'h1234, 0, 1, 0, 1, 0);
    issue(1, 2'b10, 64'h0001, 0, 16'h1235, 0, 2, 0, 1, 0);
    issue(1, 2'b01, 64'h0005, 0, 16'h0005, 0, 3, 0, 1, 0);

    // Reset during the second SUM cycle must abort without a done pulse.
    @(negedge clk);
    start4 = 1'b1; mode4 = 2'b00; ops4 = {4{16'h0001}};
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_result", res4, 0);
    check("abort_carry",  cy4,  0);
    check("abort_ovr",    ov4,  0);
    check("abort_busy",   busy4, 0);
    check("abort_done",   done4, 0);
    check("abort_count",  cnt4, 0);
    repeat (8) @(negedge clk);

    check("n_done4",    n_done4, 9);
    check("n_done1",    n_done1, 3);
    check("busy1_ever", busy1_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
